// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers sequencer samples in a FIFO, paces reads with audio_rdy
// and plays samples at a fixed rate as 8-bit PWM.
module audio_pwm_out #(
  parameter int SAMPLE_DIV  = 2268,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic        set_track,
  input  logic        read_req,
  input  logic        read_ack,
  input  logic [15:0] mem_data,
  output logic        audio_rdy,
  output logic        audio_pwm,
  output logic        audio_sd,
  output logic        underrun,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SAMPLE_DIV);
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d, duty_act_q, duty_act_d;
  logic pending_q, pending_d, rdy_q, rdy_d, pwm_q, pwm_d;
  logic underrun_q, underrun_d, overflow_q, overflow_d;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [15:0] head;
  logic [7:0] unused_lsb;
  logic flush, clr, play, tick, push, pop;
  assign head = mem_q[rd_ptr_q];
  assign unused_lsb = head[7:0];
  always_comb begin
    flush = !enb || state_q == IDLE;
    clr = flush || set_track;
    play = state_q == PLAY;
    tick = play && samp_cnt_q == SW'(SAMPLE_DIV - 1);
    pop = !clr && tick && count_q != '0;
    // a pop on the same cycle frees the slot, so a full FIFO still accepts the write
    push = !clr && read_ack && (count_q < CW'(FIFO_DEPTH) || pop);
    state_d = !enb ? IDLE :
              state_q == IDLE ? PRIME :
              set_track ? PRIME :
              (state_q == PRIME && count_q >= CW'(PRIME_LEVEL)) ? PLAY : state_q;
    count_d = clr ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
    pending_d = clr ? 1'b0 : read_req ? 1'b1 : read_ack ? 1'b0 : pending_q;
    samp_cnt_d = (!play || clr || tick) ? '0 : samp_cnt_q + SW'(1);
    pwm_cnt_d = (play && !clr) ? pwm_cnt_q + 8'd1 : 8'd0;
    duty_d = clr ? 8'h80 : tick ? (pop ? {~head[15], head[14:8]} : 8'h80) : duty_q;
    // new duty is latched only at the PWM period boundary to avoid mid-period glitches
    duty_act_d = (!play || clr) ? 8'h80 : pwm_cnt_q == 8'hff ? duty_q : duty_act_q;
    pwm_d = play && !clr && pwm_cnt_q < duty_act_q;
    underrun_d = clr ? 1'b0 : underrun_q | (tick && count_q == '0);
    overflow_d = flush ? 1'b0 : overflow_q | (!set_track && read_ack && !push);
    rdy_d = enb && state_q != IDLE && !set_track && !pending_q && !read_req && !read_ack &&
            count_d <= CW'(FIFO_DEPTH - 2);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pending_q <= 1'b0;
      samp_cnt_q <= '0;
      pwm_cnt_q <= 8'd0;
      duty_q <= 8'h80;
      duty_act_q <= 8'h80;
      pwm_q <= 1'b0;
      rdy_q <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pending_q <= pending_d;
      samp_cnt_q <= samp_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q <= duty_d;
      duty_act_q <= duty_act_d;
      pwm_q <= pwm_d;
      rdy_q <= rdy_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mem_data;
  end
  assign audio_rdy = rdy_q;
  assign audio_pwm = pwm_q;
  assign audio_sd = state_q == PLAY;
  assign underrun = underrun_q;
  assign overflow = overflow_q;
endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
- Audio output stage directly downstream of the memory-read sequencer.
- Accepts one 16-bit sample per memory read handshake and buffers it in a small FIFO.
- Generates the `audio_rdy` request-pacing signal back to the sequencer.
- Plays buffered samples at a fixed sample rate as 8-bit PWM on the board audio jack.

Parameters:
- SAMPLE_DIV, 2268, clocks per sample period (100 MHz / 44.1 kHz); must be >= 256.
- FIFO_DEPTH, 8, sample FIFO entries (power of two, >= 4).
- PRIME_LEVEL, 4, FIFO count required before playback starts (1..FIFO_DEPTH).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enb  in  1  playback enable; same enable that drives the sequencer.
- set_track  in  1  track-change strobe; flushes buffered audio.
- read_req  in  1  sequencer read request (1-cycle pulse).
- read_ack  in  1  sequencer data-accepted pulse; mem_data valid this cycle.
- mem_data  in  16  signed 16-bit sample from memory.
- audio_rdy  out  1  registered; sequencer may issue one read when high.
- audio_pwm  out  1  PWM audio output.
- audio_sd  out  1  amplifier enable; 1 only in PLAY.
- underrun  out  1  sticky: sample tick occurred with FIFO empty in PLAY.
- overflow  out  1  sticky: read_ack arrived with FIFO full (write dropped).

Behaviour:
- Reset (reset=0, async): all outputs 0; FIFO empty (count=0, pointers 0); pending=0; state=IDLE; sample and PWM counters 0; duty=8'h80.
- States IDLE, PRIME, PLAY:
  - From any state, enb=0 -> IDLE next cycle. In IDLE: FIFO flushed, flags cleared, duty=8'h80, audio_pwm=0, audio_sd=0, audio_rdy=0.
  - IDLE -> PRIME when enb=1.
  - PRIME -> PLAY when count >= PRIME_LEVEL. Sample counter restarts at 0 on entry to PLAY.
  - set_track=1 with enb=1, in PRIME or PLAY: flush FIFO, clear pending, duty=8'h80, clear underrun, go to PRIME. A read_ack in the same cycle is discarded.
- Write side:
  - pending sets on read_req=1 and clears on read_ack=1.
  - On read_ack=1: push mem_data if count < FIFO_DEPTH; otherwise drop the sample and set overflow.
- audio_rdy:
  - Registered. Next value is 1 iff enb=1, state != IDLE, set_track=0, pending=0, read_req=0, read_ack=0, and count (post-update) <= FIFO_DEPTH-2.
  - Result: at most one outstanding read, and never more reads issued than free entries.
- Sample tick:
  - In PLAY, the sample counter counts 0..SAMPLE_DIV-1 and wraps; tick is the cycle where it equals SAMPLE_DIV-1.
  - On tick with count > 0: pop the head sample; duty <= {~s[15], s[14:8]} (signed to offset-binary, upper 8 bits).
  - On tick with count = 0: duty <= 8'h80, set underrun, remain in PLAY.
- Simultaneous push and pop: both occur and count is unchanged. A push into a full FIFO on a pop cycle is accepted, because the pop frees the slot first.
- PWM:
  - 8-bit free-running counter in PLAY (held 0 otherwise).
  - audio_pwm registered: 1 iff pwm_cnt < duty. Duty 0 gives constant 0; duty 255 gives 255/256 high.
  - A duty update takes effect at the next pwm_cnt wrap to 0, so no mid-period glitch.
- Latency:
  - read_ack -> count increment: 1 cycle.
  - Tick -> new duty visible: 1 cycle, then applied at the next PWM period boundary.
  - PLAY entry -> audio_sd=1: same cycle as state change.
- Arithmetic:
  - Count is $clog2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Sample counter is $clog2(SAMPLE_DIV) bits.

Test Plan:
- Reset/idle: hold reset=0, then release with enb=0 -> all outputs 0 for 100 cycles; audio_rdy stays 0.
- Prime/handshake: enb=1 with a sequencer model returning data 3 cycles after read_req -> exactly one read outstanding at a time. PLAY entered after the 4th read_ack; audio_sd=1 the same cycle; count never exceeds 8.
- Sample conversion: feed 16'h8000, 16'h0000, 16'h7FFF with SAMPLE_DIV=512 -> duty 8'h00, 8'h80, 8'hFF on successive ticks. Measured high time per PWM period is 0, 128, 255 clocks.
- Underrun: stop supplying data in PLAY -> at the first tick with count=0, duty=8'h80 and underrun=1 (sticky), state stays PLAY. Resuming data -> normal samples follow.
- Track change: set_track pulse in PLAY with count=6 and a read_ack in the same cycle -> count=0, state=PRIME, audio_sd=0, acked sample not stored. audio_rdy reasserts 1 cycle later.
- Async reset mid-PLAY: drive reset=0 between clock edges -> outputs clear immediately without a clock edge. enb low for one cycle -> IDLE and FIFO flushed.
